// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: reset/bubble defaults and FSM encoding.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FS_BOOT = 2'b00,
    FS_RUN  = 2'b01,
    FS_HOLD = 2'b10
  } fetch_state_e;

  // Force a byte address onto a word boundary; the low bits are simply dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// Hold register for the fetch stage: captures the visible instruction when the
// stage freezes and replays it for as long as the stage stays frozen.
module fetch_skid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        sel_hold,
  input  logic [31:0] live_inst,
  input  logic        live_valid,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  logic [31:0] hold_inst_q;
  logic [31:0] hold_inst_d;
  logic        hold_valid_q;
  logic        hold_valid_d;

  // Load the live instruction on capture, otherwise keep what is held.
  always_comb begin
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
    if (capture) begin
      hold_inst_d  = live_inst;
      hold_valid_d = live_valid;
    end else begin
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
    end
  end

  // Hold register storage with synchronous active-low reset to a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_inst_q  <= NOP_INST;
      hold_valid_q <= 1'b0;
    end else begin
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  // Present the held word while frozen, the live word otherwise.
  always_comb begin
    inst_out   = live_inst;
    inst_valid = live_valid;
    if (sel_hold) begin
      inst_out   = hold_inst_q;
      inst_valid = hold_valid_q;
    end else begin
      inst_out   = live_inst;
      inst_valid = live_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation from BIOS memory with
// one-cycle read latency, stall hold, and redirect with a single kill bubble.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_f_q;
  logic [31:0]  pc_f_d;
  logic [31:0]  pc_out_q;
  logic [31:0]  pc_out_d;
  logic         kill_q;
  logic         kill_d;
  logic         imem_en_q;
  logic         imem_en_d;
  logic         capture;
  logic         sel_hold;
  logic [31:0]  live_inst;
  logic         live_valid;

  // Next-state logic: redirect beats stall in every state; leaving HOLD
  // re-issues the held-back fetch PC, so that first returning slot is killed.
  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    pc_out_d = pc_out_q;
    kill_d   = kill_q;
    capture  = 1'b0;
    if (redirect_valid) begin
      state_d = FS_RUN;
      pc_f_d  = align_word(redirect_pc);
      kill_d  = 1'b1;
    end else begin
      case (state_q)
        FS_BOOT: begin
          state_d  = FS_RUN;
          pc_f_d   = pc_f_q + PC_STEP;
          pc_out_d = pc_f_q;
          kill_d   = 1'b0;
        end
        FS_RUN: begin
          if (stall) begin
            state_d = FS_HOLD;
            capture = 1'b1;
          end else begin
            pc_f_d   = pc_f_q + PC_STEP;
            pc_out_d = pc_f_q;
            kill_d   = 1'b0;
          end
        end
        FS_HOLD: begin
          if (stall) begin
            state_d = FS_HOLD;
          end else begin
            state_d = FS_RUN;
            kill_d  = 1'b1;
          end
        end
        default: begin
          state_d = FS_BOOT;
          pc_f_d  = RESET_PC;
          kill_d  = 1'b0;
        end
      endcase
    end
    imem_en_d = (state_d != FS_HOLD);
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FS_BOOT;
      pc_f_q    <= RESET_PC;
      pc_out_q  <= 32'h0000_0000;
      kill_q    <= 1'b0;
      imem_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_out_q  <= pc_out_d;
      kill_q    <= kill_d;
      imem_en_q <= imem_en_d;
    end
  end

  // Live instruction: memory data passes straight through in RUN unless killed.
  always_comb begin
    live_inst  = NOP_INST;
    live_valid = 1'b0;
    case (state_q)
      FS_RUN: begin
        if (kill_q) begin
          live_inst  = NOP_INST;
          live_valid = 1'b0;
        end else begin
          live_inst  = imem_rdata;
          live_valid = 1'b1;
        end
      end
      default: begin
        live_inst  = NOP_INST;
        live_valid = 1'b0;
      end
    endcase
  end

  assign sel_hold = (state_q == FS_HOLD);

  fetch_skid_reg #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .sel_hold   (sel_hold),
    .live_inst  (live_inst),
    .live_valid (live_valid),
    .inst_out   (inst_out),
    .inst_valid (inst_valid)
  );

  assign imem_en   = imem_en_q;
  assign imem_addr = pc_f_q;
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural BIOS memory, scoreboard of
// expected pc sequence consumed on every accepted (valid and not stalled) output.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;

  logic        imem_en_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] inst_out_w;
  logic [31:0] pc_out_w;
  logic        inst_valid_w;

  logic        rand_mode;
  logic        sb_on;
  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en_w),
    .imem_addr      (imem_addr_w),
    .imem_rdata     (imem_rdata_w),
    .inst_out       (inst_out_w),
    .pc_out         (pc_out_w),
    .inst_valid     (inst_valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h0640_0093;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // BIOS memory model: synchronous read, optional random garbage on the bus.
  always @(posedge clk) begin
    if (rand_mode) imem_rdata <= $urandom;
    else if (imem_en) imem_rdata <= mem_word(imem_addr);
    if (imem_en_w) imem_rdata_w <= mem_word(imem_addr_w);
  end

  // Scoreboard consumer: each accepted instruction must match the next queued pc.
  always @(negedge clk) begin
    if (sb_on && inst_valid === 1'b1 && !stall) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL sb_unexpected: pc_out=%h accepted with nothing queued", pc_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks = checks + 1;
        if (pc_out !== e) begin
          failures = failures + 1;
          $display("FAIL sb_pc: got %h expected %h", pc_out, e);
        end
        checks = checks + 1;
        if (inst_out !== mem_word(e)) begin
          failures = failures + 1;
          $display("FAIL sb_inst: got %h expected %h (pc %h)", inst_out, mem_word(e), e);
        end
      end
    end
  end

  // Stimulus helper: reset both DUTs, return at start of the first RUN cycle.
  task automatic do_reset();
    sb_on = 1'b0;
    exp_q.delete();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; rand_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; rand_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out: got %h expected %h", pc_out, 32'h0); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL rst_inst: got %h expected %h", inst_out, NOP); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RPC); end
    checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL rst_en: got %b expected 1", imem_en); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL boot_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL boot_inst: got %h expected %h", inst_out, NOP); end
    @(posedge clk); #1;
  endtask

  task automatic test_boot_fetch();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(RPC + 32'(i * 4));
    sb_on = 1'b1;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b expected 1", inst_valid); end
    checks++; if (inst_out !== 32'h0640_0093) begin failures++; $display("FAIL first_inst: got %h expected %h", inst_out, 32'h0640_0093); end
    checks++; if (pc_out !== RPC) begin failures++; $display("FAIL first_pc: got %h expected %h", pc_out, RPC); end
    @(posedge clk); #1;
  endtask

  task automatic test_free_run();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL run_valid: cycle %0d got %b expected 1", i, inst_valid); end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL run_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(RPC + 32'(i * 4));
    sb_on = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1; rand_mode = 1'b1;
    @(negedge clk);
    checks++; if (pc_out !== RPC + 32'h8) begin failures++; $display("FAIL stall_entry_pc: got %h expected %h", pc_out, RPC + 32'h8); end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pc_out !== RPC + 32'h8) begin failures++; $display("FAIL hold_pc: got %h expected %h", pc_out, RPC + 32'h8); end
      checks++; if (inst_out !== mem_word(RPC + 32'h8)) begin failures++; $display("FAIL hold_inst: got %h expected %h", inst_out, mem_word(RPC + 32'h8)); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL hold_valid: got %b expected 1", inst_valid); end
      checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL hold_en: got %b expected 0", imem_en); end
      checks++; if (imem_addr !== RPC + 32'hC) begin failures++; $display("FAIL hold_addr: got %h expected %h", imem_addr, RPC + 32'hC); end
      @(posedge clk); #1;
    end
    stall = 1'b0; rand_mode = 1'b0;
    @(negedge clk);
    checks++; if (pc_out !== RPC + 32'h8) begin failures++; $display("FAIL release_pc: got %h expected %h", pc_out, RPC + 32'h8); end
    checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL release_en: got %b expected 0", imem_en); end
    @(posedge clk); #1;
    n = 0;
    while (exp_q.size() != 0 && n < 12) begin @(posedge clk); #1; n++; end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    int n;
    exp_q.push_back(RPC + 32'h14);
    exp_q.push_back(RPC + 32'h100);
    exp_q.push_back(RPC + 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0103;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL bubble_inst: got %h expected %h", inst_out, NOP); end
    checks++; if (imem_addr !== 32'h4000_0100) begin failures++; $display("FAIL redir_addr: got %h expected %h", imem_addr, 32'h4000_0100); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pc_out !== 32'h4000_0100) begin failures++; $display("FAIL target_pc: got %h expected %h", pc_out, 32'h4000_0100); end
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL target_valid: got %b expected 1", inst_valid); end
    @(posedge clk); #1;
    n = 0;
    while (exp_q.size() != 0 && n < 12) begin @(posedge clk); #1; n++; end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redir_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stall_redirect();
    int n;
    exp_q.push_back(RPC + 32'h40);
    exp_q.push_back(RPC + 32'h44);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000_0040;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL sr_bubble_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL sr_bubble_inst: got %h expected %h", inst_out, NOP); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL sr_hold_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL sr_hold_inst: got %h expected %h", inst_out, NOP); end
    checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL sr_hold_en: got %b expected 0", imem_en); end
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (exp_q.size() != 0 && n < 12) begin @(posedge clk); #1; n++; end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sr_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_hold_reset();
    sb_on = 1'b0;
    stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL hr_in_hold: got %b expected 0", imem_en); end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL hr_pc_out: got %h expected %h", pc_out, 32'h0); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL hr_inst: got %h expected %h", inst_out, NOP); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL hr_valid: got %b expected 0", inst_valid); end
    checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL hr_addr: got %h expected %h", imem_addr, RPC); end
    rst = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = 32'hFFFF_FFF8 + 32'(i * 4);
      @(negedge clk);
      checks++; if (pc_out_w !== e) begin failures++; $display("FAIL wrap_pc: got %h expected %h", pc_out_w, e); end
      checks++; if (inst_valid_w !== 1'b1) begin failures++; $display("FAIL wrap_valid: got %b expected 1", inst_valid_w); end
      checks++; if (inst_out_w !== mem_word(e)) begin failures++; $display("FAIL wrap_inst: got %h expected %h", inst_out_w, mem_word(e)); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; sb_on = 1'b0; rand_mode = 1'b0;
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_boot_fetch();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_hold_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, is the first fetch address after reset (BIOS base).
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low (asserted when 0).
REQ-005 stall  input  1  downstream not ready; hold the fetch PC and outputs.
REQ-006 redirect_valid  input  1  branch/jump resolved taken this cycle.
REQ-007 redirect_pc  input  32  target byte address.
REQ-008 imem_en  output  1  BIOS memory read enable.
REQ-009 imem_addr  output  32  BIOS read byte address (word aligned).
REQ-010 imem_rdata  input  32  BIOS read data, valid exactly one cycle after an enabled read.
REQ-011 inst_out  output  32  fetched instruction to decode.
REQ-012 pc_out  output  32  byte address of inst_out.
REQ-013 inst_valid  output  1  inst_out/pc_out carry a real instruction.

Function
REQ-014 Fetch PC register pc_f SHALL drive imem_addr directly; imem_en SHALL be 1 in RUN and BOOT, 0 in HOLD.
REQ-015 Read latency SHALL be one cycle: an address issued in cycle N SHALL appear on inst_out in cycle N+1 with pc_out equal to that address.
REQ-016 FSM states: BOOT (first cycle after reset release, no data returning), RUN, HOLD.
REQ-017 BOOT -> RUN unconditionally after one cycle; inst_valid SHALL be 0 in BOOT.
REQ-018 RUN: pc_f <= pc_f + 4 each cycle; inst_out SHALL pass imem_rdata through; inst_valid = 1 unless a kill is pending.
REQ-019 RUN -> HOLD when stall=1 and redirect_valid=0; the instruction visible in that cycle SHALL be captured into an internal hold register.
REQ-020 HOLD: pc_f, pc_out, inst_out and inst_valid SHALL remain constant regardless of imem_rdata; HOLD -> RUN when stall=0, with the next read issued at the unchanged pc_f.
REQ-021 Redirect SHALL take priority over stall in every state: pc_f <= {redirect_pc[31:2], 2'b00}, state -> RUN.
REQ-022 In the cycle after a redirect, inst_valid SHALL be 0 and inst_out = NOP_INST (one bubble, killing the wrong-path word); the target SHALL appear on the following cycle.
REQ-023 redirect_pc[1:0] SHALL be ignored (forced to zero); no exception is raised.
REQ-024 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-025 Simultaneous stall and redirect: redirect applies, stall is ignored for that cycle; if stall is still 1 in the bubble cycle, the block SHALL enter HOLD holding the bubble (inst_valid=0).

Reset
REQ-026 While rst=0 at a clock edge: pc_f = RESET_PC, state = BOOT, pc_out = 0, inst_out = NOP_INST, inst_valid = 0, kill flag cleared.
REQ-027 Reset asserted mid-operation (including in HOLD or bubble) SHALL override all other inputs on that edge.
REQ-028 First valid output SHALL be inst_out = mem[RESET_PC], pc_out = RESET_PC, two cycles after the first edge with rst=1.

Structure
REQ-029 NOP_INST and RESET_PC defaults SHALL live in the shared CPU constants package, together with the FSM state encoding typedef.
REQ-030 The hold register plus its select mux SHALL be one sub-module, fetch_skid_reg; all remaining logic stays in fetch_stage.

Verification
REQ-031 Reset release with mem[0x4000_0000]=0x0640_0093 -> two cycles later inst_valid=1, inst_out=0x0640_0093, pc_out=0x4000_0000.
REQ-032 Free run 8 cycles -> pc_out sequence 0x4000_0000..0x4000_001C step 4, inst_valid constantly 1.
REQ-033 stall=1 for 3 cycles while pc_out=0x4000_0008 and imem_rdata driven random -> outputs frozen, imem_en=0; after release pc_out=0x4000_000C next.
REQ-034 redirect_valid=1, redirect_pc=0x4000_0103 -> next cycle inst_valid=0, inst_out=0x0000_0013; following cycle pc_out=0x4000_0100, inst_valid=1.
REQ-035 Stall and redirect (target 0x4000_0040) same cycle, stall held 2 more cycles -> bubble held with inst_valid=0, then pc_out=0x4000_0040.
REQ-036 RESET_PC=0xFFFF_FFF8 run 3 cycles -> pc_out 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst=0 during HOLD -> reset values on that edge.
